// File: rtl/alu_multicycle.sv
// Multi-cycle ALU for the execute stage. Operands and a 4-bit operation
// code arrive over a valid/ready handshake. Logic, arithmetic and compare
// ops finish on the accept edge. Shifts move one bit per cycle. The result
// and flag are held until the downstream stage takes them.
module alu_multicycle #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            operation,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  flag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_XOR = 4'b0100,
    OP_SLL = 4'b0101,
    OP_SRL = 4'b0110,
    OP_SRA = 4'b0111,
    OP_EQ  = 4'b1000,
    OP_NE  = 4'b1001,
    OP_LT  = 4'b1010,
    OP_GE  = 4'b1011
  } op_t;

  state_t                 state, next_state;
  logic [3:0]             op_q;
  logic [DATA_WIDTH-1:0]  acc;
  logic [SHAMT_W-1:0]     cnt;

  logic [SHAMT_W-1:0]     shamt;
  logic                   in_is_shift;
  logic                   start_shift;
  logic [DATA_WIDTH-1:0]  imm_result;
  logic                   imm_flag;
  logic                   cond;
  logic                   is_cmp;
  logic [DATA_WIDTH-1:0]  acc_next;

  assign shamt       = src_b[SHAMT_W-1:0];
  assign in_is_shift = (operation == OP_SLL) || (operation == OP_SRL) ||
                       (operation == OP_SRA);
  assign start_shift = in_is_shift && (shamt != '0);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Single-cycle result for everything that does not need the shifter;
  // a zero-distance shift passes src_a through unchanged.
  always_comb begin
    imm_result = '0;
    cond       = 1'b0;
    is_cmp     = 1'b0;
    case (operation)
      OP_AND: imm_result = src_a & src_b;
      OP_OR:  imm_result = src_a | src_b;
      OP_ADD: imm_result = src_a + src_b;
      OP_SUB: imm_result = src_a - src_b;
      OP_XOR: imm_result = src_a ^ src_b;
      OP_SLL, OP_SRL, OP_SRA: imm_result = src_a;
      OP_EQ: begin
        is_cmp = 1'b1;
        cond   = (src_a == src_b);
      end
      OP_NE: begin
        is_cmp = 1'b1;
        cond   = (src_a != src_b);
      end
      OP_LT: begin
        is_cmp = 1'b1;
        cond   = ($signed(src_a) < $signed(src_b));
      end
      OP_GE: begin
        is_cmp = 1'b1;
        cond   = ($signed(src_a) >= $signed(src_b));
      end
      default: imm_result = '0;
    endcase
    if (is_cmp) begin
      imm_result = DATA_WIDTH'(cond);
      imm_flag   = cond;
    end else if (operation[3]) begin
      imm_flag   = 1'b0;
    end else begin
      imm_flag   = (imm_result == '0);
    end
  end

  // One-bit shift step of the accumulator for the latched shift op.
  always_comb begin
    acc_next = acc;
    case (op_q)
      OP_SLL:  acc_next = {acc[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  acc_next = {1'b0, acc[DATA_WIDTH-1:1]};
      OP_SRA:  acc_next = {acc[DATA_WIDTH-1], acc[DATA_WIDTH-1:1]};
      default: acc_next = acc;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_valid) next_state = start_shift ? SHIFT : DONE;
      end
      SHIFT: begin
        if (cnt == SHAMT_W'(1)) next_state = DONE;
      end
      DONE: begin
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  // Datapath: latch op and operands on accept, step the shifter, and
  // load result/flag when the op completes. A flush freezes all of it.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      flag   <= 1'b0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q <= operation;
            if (start_shift) begin
              acc <= src_a;
              cnt <= shamt;
            end else begin
              result <= imm_result;
              flag   <= imm_flag;
            end
          end
        end
        SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            result <= acc_next;
            flag   <= (acc_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle with hand-computed expectations.
// Latency is counted as rising edges after the accept edge until out_valid.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  operation = 4'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        flag;

  int errors = 0;
  int checks = 0;

  alu_multicycle #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag      (flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Wait for out_valid with a bound, then check latency, result and flag.
  task automatic wait_done(input string tag, input logic [31:0] exp_res,
                           input logic exp_flag, input int exp_lat,
                           input logic pop);
    int n = 0;
    logic busy_bad = 1'b0;
    while (!out_valid && n < 64) begin
      if (in_ready) busy_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_busy"}, 32'(busy_bad), 32'd0);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_flag"}, 32'(flag), 32'(exp_flag));
    if (pop) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_idle"}, 32'(in_ready), 32'd1);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_flag,
                        input int exp_lat, input logic pop);
    operation = op;
    src_a     = a;
    src_b     = b;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    operation = 4'hF;
    src_a     = 32'hA5A5A5A5;
    src_b     = 32'h5A5A5A5A;
    wait_done(tag, exp_res, exp_flag, exp_lat, pop);
  endtask

  initial begin
    // Reset held two cycles.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ovalid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flag", 32'(flag), 32'd0);
    check("rst_iready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Arithmetic and logic.
    run_op("add", 4'b0010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 0, 1'b1);
    run_op("sub", 4'b0011, 32'd5, 32'd5, 32'h0, 1'b1, 0, 1'b1);
    run_op("and", 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 0, 1'b1);
    run_op("or",  4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 0, 1'b1);
    run_op("xor", 4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 0, 1'b1);

    // Shifts.
    run_op("sra", 4'b0111, 32'h80000000, 32'h4, 32'hF8000000, 1'b0, 4, 1'b1);
    run_op("sll", 4'b0101, 32'h1, 32'h25, 32'h20, 1'b0, 5, 1'b1);
    run_op("srl0", 4'b0110, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1'b1);
    run_op("srl31", 4'b0110, 32'h80000000, 32'd31, 32'h1, 1'b0, 31, 1'b1);
    run_op("srahi", 4'b0111, 32'h80000000, 32'hFFFFFFE1, 32'hC0000000, 1'b0, 1, 1'b1);
    run_op("sllz", 4'b0101, 32'h80000000, 32'h1, 32'h0, 1'b1, 1, 1'b1);

    // Compares and unused codes.
    run_op("lt", 4'b1010, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b1, 0, 1'b1);
    run_op("ge", 4'b1011, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 0, 1'b1);
    run_op("eq", 4'b1000, 32'h1234, 32'h1234, 32'h1, 1'b1, 0, 1'b1);
    run_op("ne", 4'b1001, 32'h1, 32'h2, 32'h1, 1'b1, 0, 1'b1);
    run_op("opc", 4'b1100, 32'h1, 32'h2, 32'h0, 1'b0, 0, 1'b1);

    // Backpressure: hold DONE for 3 cycles with a new request pending.
    run_op("bp", 4'b0010, 32'h10, 32'h20, 32'h30, 1'b0, 0, 1'b0);
    operation = 4'b0011;
    src_a     = 32'h1;
    src_b     = 32'h1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_ovalid", 32'(out_valid), 32'd1);
      check("bp_res", result, 32'h30);
      check("bp_flag", 32'(flag), 32'd0);
      check("bp_iready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle", 32'(in_ready), 32'd1);
    check("bp_drop", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("bp_noacc", 32'(out_valid), 32'd0);
    check("bp_keep", result, 32'h30);

    // Flush mid-shift (SLL by 8, flushed with 3 steps remaining).
    operation = 4'b0101;
    src_a     = 32'h1;
    src_b     = 32'h8;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("fl_busy", 32'(in_ready), 32'd0);
    flush     = 1'b1;
    in_valid  = 1'b1;
    operation = 4'b0010;
    src_a     = 32'd3;
    src_b     = 32'd4;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_ovalid", 32'(out_valid), 32'd0);
    check("fl_idle", 32'(in_ready), 32'd1);
    check("fl_keep", result, 32'h30);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done("fl_next", 32'd7, 1'b0, 0, 1'b1);

    // Flush in DONE drops the handshake but keeps the result.
    run_op("fld", 4'b0001, 32'h100, 32'h1, 32'h101, 1'b0, 0, 1'b0);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    check("fld_ovalid", 32'(out_valid), 32'd0);
    check("fld_keep", result, 32'h101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
